csa_cpa_iter: RTL and testbench
===============================

# csa_cpa_iter

Iterative carry-propagate adder that resolves the redundant sum/carry vectors produced by the fmac carry-save tree into one binary value. It sits behind the CSA stage and consumes one (sum, carry) pair per transaction. It adds the pair chunk by chunk, one chunk per cycle, with a registered inter-chunk carry. This trades latency for a short critical path in area-constrained FPU configurations.

## Interface
- n, 49: width of the carry-save operand vectors; same n as the CSA stage.
- W, 16: chunk width added per cycle; 1 ≤ W ≤ n+1.
- Derived: NCHUNK = ceil((n+2)/W), the number of chunks; padded width P = NCHUNK*W.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Sum_DI  in  n  CSA sum vector; bit i has weight 2^i.
- Carry_DI  in  n  CSA carry vector; bit i has weight 2^(i+1).
- In_Valid_SI  in  1  input pair valid.
- In_Ready_SO  out  1  block can accept a pair.
- Flush_SI  in  1  synchronous abort of the current transaction.
- Result_DO  out  n+2  Sum + 2·Carry, exact, with no truncation.
- Out_Valid_SO  out  1  Result_DO is valid.
- Out_Ready_SI  in  1  downstream accepts the result.

## Operation
- Operand extension on accept:
  - A = zero-extended Sum, padded to P bits.
  - B = {Carry, 1'b0}, zero-extended to P bits.
  - Both are latched into operand registers.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - In_Ready_SO=1.
  - On In_Valid_SI=1: latch the operands, clear the chunk counter k and the carry register, go to BUSY.
- BUSY:
  - Each cycle: {c, R[k·W +: W]} = A[k·W +: W] + B[k·W +: W] + c_reg; then c_reg←c and k←k+1.
  - When k=NCHUNK−1: go to DONE.
  - In_Ready_SO=0.
- DONE:
  - Out_Valid_SO=1, and Result_DO = R[n+1:0].
  - On Out_Ready_SI=1: go to IDLE.
  - In_Ready_SO=0.
- Final carry out of chunk NCHUNK−1 is always 0, because the padding guarantees headroom. It is discarded.
- Flush_SI=1 in any state: next state is IDLE, and k and c_reg are cleared.
  - Result_DO holds its value.
  - A handshake in the same cycle is ignored. Flush wins over In_Valid_SI in IDLE and over Out_Ready_SI in DONE.
- Asynchronous reset asserted in any state, including mid-BUSY:
  - State goes to IDLE immediately; k, c_reg, operand registers and R are cleared.
  - Outputs: In_Ready_SO=1 once reset is released, Out_Valid_SO=0, Result_DO=0.
- Result_DO changes only in BUSY. It is stable for the whole of DONE and holds its last value in IDLE.

## Timing
- Accept at clock edge t → Out_Valid_SO=1 after edge t+NCHUNK. The default is 4 cycles (n=49, W=16, P=64).
- Throughput: at most one transaction per NCHUNK+2 cycles. There is no accept in DONE, so at least one IDLE cycle separates transactions.
- In_Ready_SO and Out_Valid_SO are decoded from registered state only. There is no combinational path from any input to any output.
- Valid/ready rule: a transfer happens on a rising edge where valid=1 and ready=1. Once a result is presented, it and Out_Valid_SO hold until that transfer.

## Structure
- Shared package fpu_defs_fmac holds:
  - the C_CSA_N constant (49);
  - the chunk width constant;
  - the state typedef enum {IDLE, BUSY, DONE}.
- Sub-module cpa_chunk_add: combinational W-bit adder with carry-in and carry-out. It is instantiated once and reused every cycle, indexed by k.
- Top level holds the FSM, the counter, the operand registers, c_reg and R.

## Test plan
- Sum=1, Carry=1, accepted at edge t → Out_Valid_SO rises after edge t+4; Result_DO=3; In_Ready_SO=0 from t to the handshake.
- Sum=0x1_FFFF_FFFF_FFFF, Carry=0x1_FFFF_FFFF_FFFF → Result_DO=0x5_FFFF_FFFF_FFFD. This checks carry ripple across all 4 chunks, with bit 50 set.
- Result held with Out_Ready_SI=0 for 5 cycles → Out_Valid_SO and Result_DO stay constant and In_Ready_SO=0. Then Out_Ready_SI=1 → IDLE on the next edge.
- Flush_SI pulsed while k=2 → IDLE next cycle and Out_Valid_SO never asserts. A following Sum=5, Carry=0 gives Result_DO=5.
- Rst_RBI driven low asynchronously, mid-clock, during BUSY → Out_Valid_SO=0 and Result_DO=0 immediately. In_Ready_SO=1 after reset is released.
- In_Valid_SI held high with random pairs for 1000 transactions → every Result_DO equals the golden Sum+2·Carry; no pair is lost or duplicated; at least one IDLE cycle separates transactions.

Source files
------------

// File: rtl/fpu_defs_fmac.sv
// Shared definitions for the fmac datapath: operand width, CPA chunk width and CPA FSM states.
package fpu_defs_fmac;

  localparam int unsigned C_CSA_N = 49;
  localparam int unsigned C_CPA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cpa_state_e;

  // The +2 leaves room for the doubled carry vector and the final carry, so nothing is truncated.
  function automatic int unsigned cpa_nchunk(input int unsigned n, input int unsigned w);
    return (n + 2 + w - 1) / w;
  endfunction

endpackage

// File: rtl/csa_cpa_iter_chunk_add.sv
// Combinational W-bit adder slice with carry-in/carry-out, reused once per cycle by csa_cpa_iter.
module cpa_chunk_add #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/csa_cpa_iter.sv
// Iterative carry-propagate adder: resolves a CSA (sum, carry) pair into Sum + 2*Carry,
// one W-bit chunk per cycle with a registered inter-chunk carry.
module csa_cpa_iter
  import fpu_defs_fmac::*;
#(
  parameter int unsigned n = C_CSA_N,
  parameter int unsigned W = C_CPA_W
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic [n-1:0] Sum_DI,
  input  logic [n-1:0] Carry_DI,
  input  logic         In_Valid_SI,
  output logic         In_Ready_SO,
  input  logic         Flush_SI,
  output logic [n+1:0] Result_DO,
  output logic         Out_Valid_SO,
  input  logic         Out_Ready_SI
);

  localparam int unsigned NCHUNK = cpa_nchunk(n, W);
  localparam int unsigned P      = NCHUNK * W;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLast = KW'(NCHUNK - 1);

  cpa_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic [P-1:0]  a_q, a_d;
  logic [P-1:0]  b_q, b_d;
  logic [P-1:0]  r_q, r_d;

  logic [31:0]   base;
  logic [W-1:0]  a_chunk, b_chunk, s_chunk;
  logic          c_out;

  assign base    = 32'(k_q) * W;
  assign a_chunk = a_q[base +: W];
  assign b_chunk = b_q[base +: W];

  cpa_chunk_add #(
    .W (W)
  ) u_chunk_add (
    .a_i (a_chunk),
    .b_i (b_chunk),
    .c_i (c_q),
    .s_o (s_chunk),
    .c_o (c_out)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;

    if (Flush_SI) begin
      // Abort beats any handshake; R deliberately keeps whatever was already written.
      state_d = IDLE;
      k_d     = '0;
      c_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (In_Valid_SI) begin
            a_d     = {{(P - n){1'b0}}, Sum_DI};
            b_d     = {{(P - n - 1){1'b0}}, Carry_DI, 1'b0};
            k_d     = '0;
            c_d     = 1'b0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          r_d[base +: W] = s_chunk;
          c_d            = c_out;
          if (k_q == KLast) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DONE: begin
          if (Out_Ready_SI) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  assign In_Ready_SO  = (state_q == IDLE);
  assign Out_Valid_SO = (state_q == DONE);
  assign Result_DO    = r_q[n+1:0];

  // Padding bits above n+1 only absorb the final (always zero) carry.
  if (P > n + 2) begin : gen_pad
    logic unused_pad;
    assign unused_pad = ^r_q[P-1:n+2];
  end

endmodule

// File: tb/tb_csa_cpa_iter.sv
// Self-checking bench for csa_cpa_iter: directed scenarios plus a randomized streaming run.
module tb_csa_cpa_iter;

  localparam int N      = 49;
  localparam int W      = 16;
  localparam int NCHUNK = (N + 2 + W - 1) / W;
  localparam int NTXN   = 1000;

  logic         Clk_CI = 1'b0;
  logic         Rst_RBI = 1'b0;
  logic [N-1:0] Sum_DI = '0;
  logic [N-1:0] Carry_DI = '0;
  logic         In_Valid_SI = 1'b0;
  logic         In_Ready_SO;
  logic         Flush_SI = 1'b0;
  logic [N+1:0] Result_DO;
  logic         Out_Valid_SO;
  logic         Out_Ready_SI = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 Clk_CI = ~Clk_CI;

  csa_cpa_iter #(
    .n (N),
    .W (W)
  ) dut (
    .Clk_CI       (Clk_CI),
    .Rst_RBI      (Rst_RBI),
    .Sum_DI       (Sum_DI),
    .Carry_DI     (Carry_DI),
    .In_Valid_SI  (In_Valid_SI),
    .In_Ready_SO  (In_Ready_SO),
    .Flush_SI     (Flush_SI),
    .Result_DO    (Result_DO),
    .Out_Valid_SO (Out_Valid_SO),
    .Out_Ready_SI (Out_Ready_SI)
  );

  function automatic logic [N+1:0] golden(input logic [N-1:0] s, input logic [N-1:0] c);
    logic [N+1:0] ws, wc;
    ws = s;
    wc = c;
    return ws + wc * 2;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [63:0] t;
    int unsigned sel;
    t   = {$urandom, $urandom};
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return t[N-1:0];
  endfunction

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (Out_Valid_SO !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b want 0", Out_Valid_SO); end
    total++; if (Result_DO !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", Result_DO); end
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    tick();
    total++; if (In_Ready_SO !== 1'b1) begin bad++; $display("FAIL reset_iready: got %b want 1", In_Ready_SO); end
  endtask

  // Full transaction from IDLE: latency, busy flags, optional back-pressure hold, handshake.
  task automatic do_txn(input string name, input logic [N-1:0] s, input logic [N-1:0] c,
                        input int hold);
    logic [N+1:0] exp;
    exp = golden(s, c);
    total++; if (In_Ready_SO !== 1'b1) begin bad++; $display("FAIL %s_pre_iready: got %b want 1", name, In_Ready_SO); end
    Sum_DI = s; Carry_DI = c; In_Valid_SI = 1'b1; Out_Ready_SI = 1'b0;
    tick();
    In_Valid_SI = 1'b0;
    total++; if (In_Ready_SO !== 1'b0) begin bad++; $display("FAIL %s_busy_iready: got %b want 0", name, In_Ready_SO); end
    for (int i = 1; i < NCHUNK; i++) begin
      tick();
      total++; if (Out_Valid_SO !== 1'b0 || In_Ready_SO !== 1'b0) begin
        bad++; $display("FAIL %s_early: cycle %0d ovalid=%b iready=%b want 0 0", name, i, Out_Valid_SO, In_Ready_SO);
      end
    end
    tick();
    total++; if (Out_Valid_SO !== 1'b1) begin bad++; $display("FAIL %s_latency: ovalid got %b want 1", name, Out_Valid_SO); end
    total++; if (Result_DO !== exp) begin bad++; $display("FAIL %s_result: got %h want %h", name, Result_DO, exp); end
    for (int h = 0; h < hold; h++) begin
      tick();
      total++; if (Out_Valid_SO !== 1'b1 || Result_DO !== exp || In_Ready_SO !== 1'b0) begin
        bad++; $display("FAIL %s_hold: cycle %0d ovalid=%b res=%h iready=%b want 1 %h 0", name, h, Out_Valid_SO, Result_DO, In_Ready_SO, exp);
      end
    end
    Out_Ready_SI = 1'b1;
    tick();
    Out_Ready_SI = 1'b0;
    total++; if (Out_Valid_SO !== 1'b0 || In_Ready_SO !== 1'b1) begin
      bad++; $display("FAIL %s_handshake: ovalid=%b iready=%b want 0 1", name, Out_Valid_SO, In_Ready_SO);
    end
    total++; if (Result_DO !== exp) begin bad++; $display("FAIL %s_idle_hold: got %h want %h", name, Result_DO, exp); end
  endtask

  task automatic test_basic();
    do_txn("basic", 49'd1, 49'd1, 0);
  endtask

  task automatic test_ripple();
    do_txn("ripple", 49'h1_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 0);
    total++; if (Result_DO !== 51'h5_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL ripple_const: got %h want 5fffffffffffd", Result_DO);
    end
  endtask

  task automatic test_hold();
    do_txn("hold", rand_op(), rand_op(), 5);
  endtask

  task automatic test_flush();
    Sum_DI = rand_op(); Carry_DI = rand_op(); In_Valid_SI = 1'b1;
    tick();
    In_Valid_SI = 1'b0;
    tick();
    tick();
    Flush_SI = 1'b1;
    tick();
    Flush_SI = 1'b0;
    total++; if (In_Ready_SO !== 1'b1 || Out_Valid_SO !== 1'b0) begin
      bad++; $display("FAIL flush_idle: iready=%b ovalid=%b want 1 0", In_Ready_SO, Out_Valid_SO);
    end
    for (int i = 0; i <= NCHUNK; i++) begin
      tick();
      total++; if (Out_Valid_SO !== 1'b0) begin bad++; $display("FAIL flush_no_ovalid: cycle %0d got %b want 0", i, Out_Valid_SO); end
    end
    // Flush must also win against an accept in IDLE.
    Sum_DI = 49'd7; In_Valid_SI = 1'b1; Flush_SI = 1'b1;
    tick();
    In_Valid_SI = 1'b0; Flush_SI = 1'b0;
    total++; if (In_Ready_SO !== 1'b1) begin bad++; $display("FAIL flush_vs_accept: iready got %b want 1", In_Ready_SO); end
    do_txn("after_flush", 49'd5, 49'd0, 0);
  endtask

  task automatic test_async_reset();
    Sum_DI = rand_op() | 49'd1; Carry_DI = rand_op(); In_Valid_SI = 1'b1;
    tick();
    In_Valid_SI = 1'b0;
    tick();
    #3;
    Rst_RBI = 1'b0;
    #1;
    total++; if (Out_Valid_SO !== 1'b0) begin bad++; $display("FAIL arst_ovalid: got %b want 0", Out_Valid_SO); end
    total++; if (Result_DO !== '0) begin bad++; $display("FAIL arst_result: got %h want 0", Result_DO); end
    #2;
    Rst_RBI = 1'b1;
    #1;
    total++; if (In_Ready_SO !== 1'b1 || Out_Valid_SO !== 1'b0) begin
      bad++; $display("FAIL arst_release: iready=%b ovalid=%b want 1 0", In_Ready_SO, Out_Valid_SO);
    end
    tick();
    do_txn("after_arst", 49'd3, 49'd2, 0);
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] sb[$];
    logic [N+1:0] exp, res;
    logic rdy, ov, orr;
    int accepts = 0, outs = 0, last_acc = 0, cyc = 0;
    Sum_DI = rand_op(); Carry_DI = rand_op(); In_Valid_SI = 1'b1;
    while (outs < NTXN && cyc < 20 * NTXN) begin
      Out_Ready_SI = ($urandom_range(0, 3) != 0);
      rdy = In_Ready_SO; ov = Out_Valid_SO; res = Result_DO; orr = Out_Ready_SI;
      tick();
      cyc++;
      if (ov && orr) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_extra: result %h with nothing outstanding", res);
        end else begin
          exp = sb.pop_front();
          if (res !== exp) begin bad++; $display("FAIL b2b_result: txn %0d got %h want %h", outs, res, exp); end
        end
        outs++;
      end
      if (rdy && accepts < NTXN) begin
        sb.push_back(golden(Sum_DI, Carry_DI));
        if (accepts > 0) begin
          total++; if (cyc - last_acc < NCHUNK + 2) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles want >= %0d", cyc - last_acc, NCHUNK + 2);
          end
        end
        last_acc = cyc;
        accepts++;
        Sum_DI = rand_op(); Carry_DI = rand_op();
        if (accepts == NTXN) In_Valid_SI = 1'b0;
      end
    end
    Out_Ready_SI = 1'b0;
    total++; if (outs !== NTXN) begin bad++; $display("FAIL b2b_count: got %0d want %0d", outs, NTXN); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
